// File: rtl/axi_sram_burst_ctrl.sv
// rtl/axi_sram_burst_ctrl.sv - AXI4 slave to single-port SRAM burst serialiser
module axi_sram_burst_ctrl #(
  parameter int ID_WIDTH        = 5,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int SRAM_ADDR_WIDTH = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // write address
  input  logic [ID_WIDTH-1:0]        s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]      s_axi_awaddr,
  input  logic [7:0]                 s_axi_awlen,
  input  logic [2:0]                 s_axi_awsize,
  input  logic [1:0]                 s_axi_awburst,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]      s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]    s_axi_wstrb,
  input  logic                       s_axi_wlast,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  // write response
  output logic [ID_WIDTH-1:0]        s_axi_bid,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  // read address
  input  logic [ID_WIDTH-1:0]        s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]      s_axi_araddr,
  input  logic [7:0]                 s_axi_arlen,
  input  logic [2:0]                 s_axi_arsize,
  input  logic [1:0]                 s_axi_arburst,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  // read data
  output logic [ID_WIDTH-1:0]        s_axi_rid,
  output logic [DATA_WIDTH-1:0]      s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  // SRAM port
  output logic                       req_o,
  output logic                       we_o,
  output logic [SRAM_ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH/8-1:0]    be_o,
  output logic [DATA_WIDTH-1:0]      wdata_o,
  input  logic [DATA_WIDTH-1:0]      rdata_i
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LNB = $clog2(NB);
  localparam int HI  = SRAM_ADDR_WIDTH + LNB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t                  state;
  logic                    prio_rd;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [7:0]              cnt_q;
  logic                    err_q;
  logic                    rd_first_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    in_idle;
  logic                    both_valid;
  logic                    w_hs;
  logic                    beat_oor;
  logic                    beat_last;
  logic                    rd_req;
  logic                    wr_req;
  logic                    unused_ok;

  // Beat address after the current one, following the latched burst type.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] res;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    inc  = a + step;
    res  = inc;
    case (burst)
      2'b00: res = a;
      2'b10: begin
        // Only legal wrap lengths wrap; anything else degrades to INCR.
        if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
          res = (a & ~mask) | (inc & mask);
      end
      default: res = inc;
    endcase
    return res;
  endfunction

  // Combinational handshake and SRAM strobes derived from the current state.
  assign in_idle    = (state == IDLE) && !rst_i;
  assign both_valid = s_axi_arvalid && s_axi_awvalid;
  assign s_axi_arready = in_idle && s_axi_arvalid && (!s_axi_awvalid || prio_rd);
  assign s_axi_awready = in_idle && s_axi_awvalid && (!s_axi_arvalid || !prio_rd);
  assign s_axi_wready  = (state == WR_DATA);

  assign w_hs      = s_axi_wready && s_axi_wvalid;
  assign beat_oor  = (addr_q >> HI) != '0;
  assign beat_last = (cnt_q == len_q);
  assign rd_req    = (state == RD_REQ) && !beat_oor;
  assign wr_req    = w_hs && !beat_oor;

  assign req_o   = rd_req || wr_req;
  assign we_o    = wr_req;
  assign addr_o  = req_o ? addr_q[HI-1:LNB] : '0;
  assign be_o    = wr_req ? s_axi_wstrb : (rd_req ? {NB{1'b1}} : '0);
  assign wdata_o = wr_req ? s_axi_wdata : '0;

  // First RD_DATA cycle passes the SRAM word straight through; later stall cycles replay the capture.
  assign s_axi_rvalid = (state == RD_DATA);
  assign s_axi_rdata  = (!s_axi_rvalid || beat_oor) ? '0 : (rd_first_q ? rdata_i : rdata_q);
  assign s_axi_rresp  = (s_axi_rvalid && beat_oor) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rlast  = s_axi_rvalid && beat_last;
  assign s_axi_rid    = id_q;

  assign s_axi_bvalid = (state == WR_RESP);
  assign s_axi_bresp  = (s_axi_bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_bid    = id_q;

  // Burst length comes from the latched len; wlast carries no extra information.
  assign unused_ok = s_axi_wlast;

  // Transaction FSM: accepts one burst, steps its beats, issues the response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      prio_rd    <= 1'b1;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_first_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axi_arready) begin
            id_q    <= s_axi_arid;
            addr_q  <= s_axi_araddr;
            len_q   <= s_axi_arlen;
            size_q  <= s_axi_arsize;
            burst_q <= s_axi_arburst;
            cnt_q   <= '0;
            if (both_valid) prio_rd <= ~prio_rd;
            state   <= RD_REQ;
          end else if (s_axi_awready) begin
            id_q    <= s_axi_awid;
            addr_q  <= s_axi_awaddr;
            len_q   <= s_axi_awlen;
            size_q  <= s_axi_awsize;
            burst_q <= s_axi_awburst;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            if (both_valid) prio_rd <= ~prio_rd;
            state   <= WR_DATA;
          end
        end
        RD_REQ: begin
          rd_first_q <= 1'b1;
          state      <= RD_DATA;
        end
        RD_DATA: begin
          rd_first_q <= 1'b0;
          if (rd_first_q) rdata_q <= rdata_i;
          if (s_axi_rready) begin
            if (beat_last) begin
              state <= IDLE;
            end else begin
              addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
              cnt_q  <= cnt_q + 8'd1;
              state  <= RD_REQ;
            end
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            if (beat_oor) err_q <= 1'b1;
            if (beat_last) begin
              state <= WR_RESP;
            end else begin
              addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
              cnt_q  <= cnt_q + 8'd1;
            end
          end
        end
        WR_RESP: begin
          if (s_axi_bready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
